cpu_control_unit: RTL and testbench

- Multi-cycle sequencer that drives the 16-bit integer datapath's control inputs: W_En, W_Adr, R_Adr, S_Adr, DS, S_Sel and Alu_Op.
- Fetches 16-bit instructions over a ready-handshaked memory port, decodes them and issues one control word per instruction.
- Latches the datapath's C/N/Z flags after each ALU operation and uses them for conditional branches.
- Sits between instruction memory and the integer datapath as the datapath's initiator.

---
 rtl/cpu_control_unit_pkg.sv | 63 ++++++
 rtl/cpu_control_unit_if.sv | 28 ++
 rtl/cpu_control_unit_instr_decode.sv | 95 +++++++++
 rtl/cpu_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the CPU control unit: instruction classes, control
// sub-ops, branch condition codes, the sequencer state enum, the latched flag
// record and the bit positions of every instruction field.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    CLS_ALU_REG = 2'b00,
    CLS_ALU_IMM = 2'b01,
    CLS_LDL     = 2'b10,
    CLS_CTRL    = 2'b11
  } instr_class_e;

  typedef enum logic [1:0] {
    SUB_BRANCH = 2'b00,
    SUB_JUMP   = 2'b01,
    SUB_HALT   = 2'b10,
    SUB_NOP    = 2'b11
  } ctrl_sub_e;

  typedef enum logic [1:0] {
    COND_Z      = 2'b00,
    COND_N      = 2'b01,
    COND_C      = 2'b10,
    COND_ALWAYS = 2'b11
  } cond_e;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_FETCH_LIT = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
  } flags_t;

  // Instruction field positions
  localparam int CLS_HI  = 15;
  localparam int CLS_LO  = 14;
  localparam int OP_HI   = 13;
  localparam int OP_LO   = 10;
  localparam int W_HI    = 9;
  localparam int W_LO    = 7;
  localparam int R_HI    = 6;
  localparam int R_LO    = 4;
  localparam int S_HI    = 3;
  localparam int S_LO    = 1;
  localparam int IMM_HI  = 3;
  localparam int IMM_LO  = 0;
  localparam int SUB_HI  = 13;
  localparam int SUB_LO  = 12;
  localparam int COND_HI = 11;
  localparam int COND_LO = 10;
  localparam int INV_BIT = 9;
  localparam int OFF_HI  = 7;
  localparam int OFF_LO  = 0;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Instruction-fetch port between the control unit (master) and instruction
// memory (slave).
//   mem_rd    : fetch request, held until accepted
//   mem_addr  : fetch address, stable while mem_rd=1
//   mem_ready : request accepted, mem_rdata valid in the same cycle
//   mem_rdata : fetched 16-bit word
interface cpu_control_unit_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_control_unit_instr_decode.sv
// Purely combinational instruction decoder.
//   ir         : latched instruction word
//   lit        : literal word currently on the memory bus (load-literal/jump)
//   flags      : latched C/N/Z flags
//   pc_next    : PC of the next instruction (already incremented)
//   cls, sub   : instruction class and control sub-op
//   alu_op, w_adr, r_adr, s_adr, ds, s_sel : control word for EXECUTE
//   upd_flags  : instruction updates the flag register in EXECUTE
//   br_taken, br_target, jmp_target : control-flow results
// ADDR_W must not exceed 16 (jump target comes from a 16-bit literal).
module instr_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int         ADDR_W     = 8,
  parameter logic [3:0] ALU_PASS_S = 4'h0
) (
  input  logic [15:0]       ir,
  input  logic [15:0]       lit,
  input  flags_t            flags,
  input  logic [ADDR_W-1:0] pc_next,
  output instr_class_e      cls,
  output ctrl_sub_e         sub,
  output logic [3:0]        alu_op,
  output logic [2:0]        w_adr,
  output logic [2:0]        r_adr,
  output logic [2:0]        s_adr,
  output logic [15:0]       ds,
  output logic              s_sel,
  output logic              upd_flags,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] jmp_target
);

  logic signed [7:0]        br_off;
  logic signed [ADDR_W+7:0] br_off_ext;
  logic                     cond_val;

  assign cls = instr_class_e'(ir[CLS_HI:CLS_LO]);
  assign sub = ctrl_sub_e'(ir[SUB_HI:SUB_LO]);

  // Offset is a signed word count relative to the already-incremented PC;
  // the sum wraps modulo 2^ADDR_W.
  assign br_off     = ir[OFF_HI:OFF_LO];
  assign br_off_ext = {{ADDR_W{br_off[7]}}, br_off};
  assign br_target  = pc_next + br_off_ext[ADDR_W-1:0];
  assign jmp_target = lit[ADDR_W-1:0];

  always_comb begin
    cond_val = 1'b0;
    case (cond_e'(ir[COND_HI:COND_LO]))
      COND_Z:      cond_val = flags.z;
      COND_N:      cond_val = flags.n;
      COND_C:      cond_val = flags.c;
      COND_ALWAYS: cond_val = 1'b1;
      default:     cond_val = 1'b0;
    endcase
    br_taken = cond_val ^ ir[INV_BIT];
  end

  always_comb begin
    alu_op    = 4'h0;
    w_adr     = 3'd0;
    r_adr     = 3'd0;
    s_adr     = 3'd0;
    ds        = 16'h0000;
    s_sel     = 1'b0;
    upd_flags = 1'b0;
    case (cls)
      CLS_ALU_REG: begin
        alu_op    = ir[OP_HI:OP_LO];
        w_adr     = ir[W_HI:W_LO];
        r_adr     = ir[R_HI:R_LO];
        s_adr     = ir[S_HI:S_LO];
        upd_flags = 1'b1;
      end
      CLS_ALU_IMM: begin
        alu_op    = ir[OP_HI:OP_LO];
        w_adr     = ir[W_HI:W_LO];
        r_adr     = ir[R_HI:R_LO];
        ds        = {{12{ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
        s_sel     = 1'b1;
        upd_flags = 1'b1;
      end
      CLS_LDL: begin
        alu_op = ALU_PASS_S;
        w_adr  = ir[W_HI:W_LO];
        ds     = lit;
        s_sel  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer driving the 16-bit integer datapath.
//   clk, reset : clock (rising edge) and asynchronous active-low reset
//   mem        : instruction-fetch master port
//   W_En, W_Adr, R_Adr, S_Adr, DS, S_Sel, Alu_Op : registered datapath
//                controls, loaded on entry to EXECUTE and held otherwise
//   C, N, Z    : datapath flags, latched at the end of ALU EXECUTE cycles
//   pc         : current program counter
//   halted     : high while in HALT
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]        ALU_PASS_S = 4'h0
) (
  input  logic                      clk,
  input  logic                      reset,
  cpu_control_unit_if.master        mem,
  output logic                      W_En,
  output logic [2:0]                W_Adr,
  output logic [2:0]                R_Adr,
  output logic [2:0]                S_Adr,
  output logic [15:0]               DS,
  output logic                      S_Sel,
  output logic [3:0]                Alu_Op,
  input  logic                      C,
  input  logic                      N,
  input  logic                      Z,
  output logic [ADDR_W-1:0]         pc,
  output logic                      halted
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_e            state;
  logic [15:0]       ir;
  flags_t            flags;
  logic              mem_rd_q;

  instr_class_e      cls;
  ctrl_sub_e         sub;
  logic [3:0]        dec_alu_op;
  logic [2:0]        dec_w_adr;
  logic [2:0]        dec_r_adr;
  logic [2:0]        dec_s_adr;
  logic [15:0]       dec_ds;
  logic              dec_s_sel;
  logic              dec_upd_flags;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_target;

  assign mem.mem_rd   = mem_rd_q;
  assign mem.mem_addr = pc;

  instr_decode #(
    .ADDR_W     (ADDR_W),
    .ALU_PASS_S (ALU_PASS_S)
  ) u_decode (
    .ir         (ir),
    .lit        (mem.mem_rdata),
    .flags      (flags),
    .pc_next    (pc),
    .cls        (cls),
    .sub        (sub),
    .alu_op     (dec_alu_op),
    .w_adr      (dec_w_adr),
    .r_adr      (dec_r_adr),
    .s_adr      (dec_s_adr),
    .ds         (dec_ds),
    .s_sel      (dec_s_sel),
    .upd_flags  (dec_upd_flags),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_target (jmp_target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_START;
      pc       <= RESET_PC;
      ir       <= 16'h0000;
      flags    <= '0;
      mem_rd_q <= 1'b0;
      W_En     <= 1'b0;
      W_Adr    <= 3'd0;
      R_Adr    <= 3'd0;
      S_Adr    <= 3'd0;
      DS       <= 16'h0000;
      S_Sel    <= 1'b0;
      Alu_Op   <= 4'h0;
      halted   <= 1'b0;
    end else begin
      case (state)
        // START keeps mem_rd low for the first cycle out of reset
        ST_START: begin
          state    <= ST_FETCH;
          mem_rd_q <= 1'b1;
        end

        ST_FETCH: begin
          if (mem.mem_ready) begin
            ir       <= mem.mem_rdata;
            pc       <= pc + PC_ONE;
            mem_rd_q <= 1'b0;
            state    <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          case (cls)
            CLS_ALU_REG, CLS_ALU_IMM: begin
              W_En   <= 1'b1;
              W_Adr  <= dec_w_adr;
              R_Adr  <= dec_r_adr;
              S_Adr  <= dec_s_adr;
              DS     <= dec_ds;
              S_Sel  <= dec_s_sel;
              Alu_Op <= dec_alu_op;
              state  <= ST_EXECUTE;
            end
            CLS_LDL: begin
              mem_rd_q <= 1'b1;
              state    <= ST_FETCH_LIT;
            end
            default: begin
              case (sub)
                SUB_BRANCH: begin
                  if (br_taken) pc <= br_target;
                  mem_rd_q <= 1'b1;
                  state    <= ST_FETCH;
                end
                SUB_JUMP: begin
                  mem_rd_q <= 1'b1;
                  state    <= ST_FETCH_LIT;
                end
                SUB_HALT: begin
                  halted <= 1'b1;
                  state  <= ST_HALT;
                end
                default: begin
                  mem_rd_q <= 1'b1;
                  state    <= ST_FETCH;
                end
              endcase
            end
          endcase
        end

        // The literal is consumed straight off the bus: DS for load-literal,
        // the new PC for jump. No separate literal register is needed.
        ST_FETCH_LIT: begin
          if (mem.mem_ready) begin
            if (cls == CLS_LDL) begin
              pc       <= pc + PC_ONE;
              mem_rd_q <= 1'b0;
              W_En     <= 1'b1;
              W_Adr    <= dec_w_adr;
              R_Adr    <= dec_r_adr;
              S_Adr    <= dec_s_adr;
              DS       <= dec_ds;
              S_Sel    <= dec_s_sel;
              Alu_Op   <= dec_alu_op;
              state    <= ST_EXECUTE;
            end else begin
              pc       <= jmp_target;
              mem_rd_q <= 1'b1;
              state    <= ST_FETCH;
            end
          end
        end

        ST_EXECUTE: begin
          W_En <= 1'b0;
          if (dec_upd_flags) flags <= '{c: C, n: N, z: Z};
          mem_rd_q <= 1'b1;
          state    <= ST_FETCH;
        end

        ST_HALT: state <= ST_HALT;

        default: begin
          mem_rd_q <= 1'b0;
          state    <= ST_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed testbench for cpu_control_unit: a behavioural instruction memory
// with a controllable ready, hand-computed expectations per scenario.
module tb_cpu_control_unit;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              C;
  logic              N;
  logic              Z;
  logic              W_En;
  logic [2:0]        W_Adr;
  logic [2:0]        R_Adr;
  logic [2:0]        S_Adr;
  logic [15:0]       DS;
  logic              S_Sel;
  logic [3:0]        Alu_Op;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  logic              ready_en;
  logic [15:0]       imem [0:255];
  logic [29:0]       ctrl_word;

  int checks   = 0;
  int failures = 0;

  cpu_control_unit_if #(.ADDR_W(ADDR_W)) mem_if ();

  assign mem_if.mem_ready = ready_en;
  assign mem_if.mem_rdata = imem[mem_if.mem_addr];
  assign ctrl_word = {W_Adr, R_Adr, S_Adr, S_Sel, Alu_Op, DS};

  cpu_control_unit #(
    .ADDR_W     (ADDR_W),
    .RESET_PC   (8'h00),
    .ALU_PASS_S (4'h0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mem    (mem_if),
    .W_En   (W_En),
    .W_Adr  (W_Adr),
    .R_Adr  (R_Adr),
    .S_Adr  (S_Adr),
    .DS     (DS),
    .S_Sel  (S_Sel),
    .Alu_Op (Alu_Op),
    .C      (C),
    .N      (N),
    .Z      (Z),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hE000;
  endtask

  task automatic start_run();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    imem[0] = 16'h0000;
    ready_en = 1'b1;
    {C, N, Z} = 3'b000;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({mem_if.mem_rd, W_En, halted} !== 3'b000) begin
      failures++; $display("FAIL rst_ctrl actual=%b required=000", {mem_if.mem_rd, W_En, halted});
    end
    checks++;
    if (pc !== 8'h00) begin
      failures++; $display("FAIL rst_pc actual=%0h required=0", pc);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_if.mem_rd !== 1'b0) begin
      failures++; $display("FAIL rst_start_rd actual=%b required=0", mem_if.mem_rd);
    end
    step();
    checks++;
    if ({mem_if.mem_rd, mem_if.mem_addr} !== {1'b1, 8'h00}) begin
      failures++; $display("FAIL rst_first_fetch actual=%0h required=100", {mem_if.mem_rd, mem_if.mem_addr});
    end
    step();
    checks++;
    if (W_En !== 1'b0) begin
      failures++; $display("FAIL rst_decode_wen actual=%b required=0", W_En);
    end
    step();
    checks++;
    if ({W_En, ctrl_word} !== {1'b1, 30'd0}) begin
      failures++; $display("FAIL rst_exec actual=%0h required=%0h", {W_En, ctrl_word}, {1'b1, 30'd0});
    end
    step();
    checks++;
    if (W_En !== 1'b0) begin
      failures++; $display("FAIL rst_wen_pulse actual=%b required=0", W_En);
    end
  endtask

  task automatic test_alu_imm();
    int n;
    clear_mem();
    imem[0] = 16'h47AF;
    start_run();
    n = 0;
    while (W_En !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n != 3) begin
      failures++; $display("FAIL imm_latency actual=%0d required=3", n);
    end
    checks++;
    if (ctrl_word !== {3'd7, 3'd2, 3'd0, 1'b1, 4'd1, 16'hFFFF}) begin
      failures++; $display("FAIL imm_ctrl actual=%0h required=%0h", ctrl_word, {3'd7, 3'd2, 3'd0, 1'b1, 4'd1, 16'hFFFF});
    end
    step();
    checks++;
    if (W_En !== 1'b0) begin
      failures++; $display("FAIL imm_wen_pulse actual=%b required=0", W_En);
    end
  endtask

  task automatic test_load_literal();
    int n;
    clear_mem();
    imem[0] = 16'h8380;
    imem[1] = 16'hBEEF;
    imem[2] = 16'hC0FE;  // branch on Z, not taken unless flags were wrongly updated
    {C, N, Z} = 3'b111;
    start_run();
    n = 0;
    while (W_En !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n != 4) begin
      failures++; $display("FAIL ldl_latency actual=%0d required=4", n);
    end
    checks++;
    if (ctrl_word !== {3'd7, 3'd0, 3'd0, 1'b1, 4'h0, 16'hBEEF}) begin
      failures++; $display("FAIL ldl_ctrl actual=%0h required=%0h", ctrl_word, {3'd7, 3'd0, 3'd0, 1'b1, 4'h0, 16'hBEEF});
    end
    checks++;
    if (pc !== 8'h02) begin
      failures++; $display("FAIL ldl_pc actual=%0h required=2", pc);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if ({halted, pc} !== {1'b1, 8'h04}) begin
      failures++; $display("FAIL ldl_no_flags actual=%0h required=104", {halted, pc});
    end
    {C, N, Z} = 3'b000;
  endtask

  task automatic test_branch();
    logic [15:0] t_instr [9] = '{16'hC0FE, 16'hC0FE, 16'hC2FE, 16'hC2FE, 16'hC4FE,
                                 16'hC4FE, 16'hC8FE, 16'hC8FE, 16'hCCFE};
    logic [2:0]  t_cnz   [9] = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b010,
                                 3'b101, 3'b100, 3'b011, 3'b000};
    logic        t_taken [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  exp_pc;
    int n;
    for (int i = 0; i < 9; i++) begin
      clear_mem();
      imem[0] = 16'h0000;
      imem[1] = t_instr[i];
      {C, N, Z} = t_cnz[i];
      start_run();
      n = 0;
      while (W_En !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (n != 3) begin
        failures++; $display("FAIL br%0d_alu_latency actual=%0d required=3", i, n);
      end
      step();
      // live flags now disagree with the latched ones
      {C, N, Z} = ~t_cnz[i];
      step();
      step();
      exp_pc = t_taken[i] ? 8'h00 : 8'h02;
      checks++;
      if ({mem_if.mem_rd, mem_if.mem_addr} !== {1'b1, exp_pc}) begin
        failures++; $display("FAIL br%0d_target actual=%0h required=%0h", i, {mem_if.mem_rd, mem_if.mem_addr}, {1'b1, exp_pc});
      end
    end
    {C, N, Z} = 3'b000;
  endtask

  task automatic test_jump();
    clear_mem();
    imem[0] = 16'hD000;
    imem[1] = 16'h0105;
    start_run();
    for (int i = 0; i < 4; i++) step();
    checks++;
    if ({mem_if.mem_rd, pc} !== {1'b1, 8'h05}) begin
      failures++; $display("FAIL jmp_target actual=%0h required=105", {mem_if.mem_rd, pc});
    end
    step();
    step();
    checks++;
    if ({halted, pc} !== {1'b1, 8'h06}) begin
      failures++; $display("FAIL jmp_halt actual=%0h required=106", {halted, pc});
    end
    // branch-always backwards from address 0 wraps to the top of memory
    clear_mem();
    imem[0] = 16'hCCFE;
    start_run();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({mem_if.mem_rd, pc} !== {1'b1, 8'hFF}) begin
      failures++; $display("FAIL br_wrap actual=%0h required=1ff", {mem_if.mem_rd, pc});
    end
  endtask

  task automatic test_stall();
    int n;
    clear_mem();
    imem[0] = 16'h0000;
    ready_en = 1'b0;
    start_run();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_if.mem_rd, mem_if.mem_addr, W_En} !== {1'b1, 8'h00, 1'b0}) begin
        failures++; $display("FAIL stall%0d actual=%0h required=200", i, {mem_if.mem_rd, mem_if.mem_addr, W_En});
      end
      step();
    end
    ready_en = 1'b1;
    n = 0;
    while (W_En !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n != 2) begin
      failures++; $display("FAIL stall_release actual=%0d required=2", n);
    end
    // reset while a fetch is pending drops the request at once
    ready_en = 1'b0;
    start_run();
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_if.mem_rd, pc} !== {1'b0, 8'h00}) begin
      failures++; $display("FAIL rst_mid_fetch actual=%0h required=0", {mem_if.mem_rd, pc});
    end
    ready_en = 1'b1;
  endtask

  task automatic test_reset_mid_execute();
    int n;
    clear_mem();
    imem[0] = 16'h47AF;
    start_run();
    n = 0;
    while (W_En !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if ({W_En, pc} !== {1'b1, 8'h01}) begin
      failures++; $display("FAIL rst_exec_pre actual=%0h required=101", {W_En, pc});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({W_En, mem_if.mem_rd, halted, pc} !== 11'd0) begin
      failures++; $display("FAIL rst_exec_ctrl actual=%0h required=0", {W_En, mem_if.mem_rd, halted, pc});
    end
    checks++;
    if (ctrl_word !== 30'd0) begin
      failures++; $display("FAIL rst_exec_outputs actual=%0h required=0", ctrl_word);
    end
  endtask

  task automatic test_halt();
    int rd_cnt;
    clear_mem();
    imem[0] = 16'hE000;
    start_run();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (halted !== 1'b1) begin
      failures++; $display("FAIL halt_enter actual=%b required=1", halted);
    end
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_if.mem_rd !== 1'b0 || halted !== 1'b1) rd_cnt++;
      step();
    end
    checks++;
    if (rd_cnt != 0) begin
      failures++; $display("FAIL halt_stay actual=%0d required=0", rd_cnt);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0) begin
      failures++; $display("FAIL halt_reset actual=%b required=0", halted);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_mem();
    imem[0] = 16'h0EBD;  // ALU-reg op3 W5 R3 S6, bit 0 set and ignored
    imem[1] = 16'h48C7;  // ALU-imm op2 W1 R4 imm 7
    start_run();
    n = 0;
    while (W_En !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (ctrl_word !== {3'd5, 3'd3, 3'd6, 1'b0, 4'd3, 16'h0000}) begin
      failures++; $display("FAIL b2b_reg_ctrl actual=%0h required=%0h", ctrl_word, {3'd5, 3'd3, 3'd6, 1'b0, 4'd3, 16'h0000});
    end
    step();
    checks++;
    if ({W_En, ctrl_word} !== {1'b0, 3'd5, 3'd3, 3'd6, 1'b0, 4'd3, 16'h0000}) begin
      failures++; $display("FAIL b2b_hold actual=%0h required=%0h", {W_En, ctrl_word}, {1'b0, 3'd5, 3'd3, 3'd6, 1'b0, 4'd3, 16'h0000});
    end
    n = 0;
    while (W_En !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n != 2) begin
      failures++; $display("FAIL b2b_gap actual=%0d required=2", n);
    end
    checks++;
    if (ctrl_word !== {3'd1, 3'd4, 3'd0, 1'b1, 4'd2, 16'h0007}) begin
      failures++; $display("FAIL b2b_imm_ctrl actual=%0h required=%0h", ctrl_word, {3'd1, 3'd4, 3'd0, 1'b1, 4'd2, 16'h0007});
    end
  endtask

  initial begin
    reset    = 1'b0;
    ready_en = 1'b1;
    C = 1'b0;
    N = 1'b0;
    Z = 1'b0;
    test_reset();
    test_alu_imm();
    test_load_literal();
    test_branch();
    test_jump();
    test_stall();
    test_reset_mid_execute();
    test_halt();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
